// File: rtl/pokey_skstat_reg.sv
// -----------------------------------------------------------------------------
// pokey_skstat_reg
//
// POKEY serial/keyboard status register (SKSTAT, read address $D20F).
// Holds three sticky error flags (framing error, keyboard overrun, serial input
// overrun) and registered copies of four live status levels. All of them are
// presented as an active-low 8-bit read value. State advances only on the
// 1.79 MHz enable strobe. A write to SKRES (addrAw) clears the sticky flags.
//
// Optional build macro:
//   SKSTAT_SYNC_IN_EN - when defined, kShift, keyDown, sdiBusy and siDelay each
//                       pass through a 2-flop clk-domain synchronizer before
//                       they are sampled on enn. When undefined, they are
//                       sampled directly.
//
// Ports:
//   clk        in   1  system clock; all state changes on the rising edge
//   reset      in   1  asynchronous, active-high reset
//   enn        in   1  one-clk-wide enable strobe; state updates only when high
//   sdiOvrun   in   1  serial data input overrun event
//   keyOvrun   in   1  keyboard overrun event
//   setFramer  in   1  serial framing error event
//   kShift     in   1  shift key held (level)
//   keyDown    in   1  key currently pressed (level)
//   sdiBusy    in   1  serial input shift register busy (level)
//   siDelay    in   1  delayed serial data input pin level
//   addrAw     in   1  SKRES write strobe; clears the sticky flags
//   Dout       out  8  SKSTAT read value (bits 7:1 active low, bit 0 = 1)
// -----------------------------------------------------------------------------
module pokey_skstat_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       sdiOvrun,
    input  logic       keyOvrun,
    input  logic       setFramer,
    input  logic       kShift,
    input  logic       keyDown,
    input  logic       sdiBusy,
    input  logic       siDelay,
    input  logic       addrAw,
    output logic [7:0] Dout
);

    // Sticky flags
    logic frame_err;
    logic key_ovr;
    logic sdi_ovr;

    // Registered live levels
    logic shift_lvl;
    logic key_lvl;
    logic busy_lvl;
    logic si_lvl;

    // Live inputs as seen by the enn sampling stage
    logic shift_in;
    logic key_in;
    logic busy_in;
    logic si_in;

`ifdef SKSTAT_SYNC_IN_EN
    // Two-stage synchronizers, bit order {si, busy, key, shift}.
    // Reset values match the idle level of each input (siDelay idles high).
    localparam logic [3:0] SYNC_RST = 4'b1000;

    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= SYNC_RST;
            sync_q2 <= SYNC_RST;
        end else begin
            sync_q1 <= {siDelay, sdiBusy, keyDown, kShift};
            sync_q2 <= sync_q1;
        end
    end

    assign shift_in = sync_q2[0];
    assign key_in   = sync_q2[1];
    assign busy_in  = sync_q2[2];
    assign si_in    = sync_q2[3];
`else
    assign shift_in = kShift;
    assign key_in   = keyDown;
    assign busy_in  = sdiBusy;
    assign si_in    = siDelay;
`endif

    // Sticky flag update: an event sets the flag, otherwise SKRES clears it.
    // Set has priority, so a flag whose event coincides with SKRES stays set.
    function automatic logic sticky_next(input logic cur, input logic event_in,
                                         input logic clr);
        if (event_in)
            return 1'b1;
        else if (clr)
            return 1'b0;
        else
            return cur;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            key_ovr   <= 1'b0;
            sdi_ovr   <= 1'b0;
            shift_lvl <= 1'b0;
            key_lvl   <= 1'b0;
            busy_lvl  <= 1'b0;
            si_lvl    <= 1'b1;
        end else if (enn) begin
            frame_err <= sticky_next(frame_err, setFramer, addrAw);
            key_ovr   <= sticky_next(key_ovr,   keyOvrun,  addrAw);
            sdi_ovr   <= sticky_next(sdi_ovr,   sdiOvrun,  addrAw);
            shift_lvl <= shift_in;
            key_lvl   <= key_in;
            busy_lvl  <= busy_in;
            si_lvl    <= si_in;
        end
    end

    // Read decode: purely combinational from registered state, so reset is
    // visible on Dout immediately. siLvl is the only non-inverted bit.
    assign Dout = {~frame_err, ~key_ovr, ~sdi_ovr, si_lvl,
                   ~shift_lvl, ~key_lvl, ~busy_lvl, 1'b1};

endmodule

// File: tb/tb_pokey_skstat_reg.sv
// -----------------------------------------------------------------------------
// Testbench for pokey_skstat_reg: directed scenarios followed by randomized
// enn ticks checked against a behavioural model of the SKSTAT register.
// -----------------------------------------------------------------------------
module tb_pokey_skstat_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       enn;
    logic       sdiOvrun, keyOvrun, setFramer;
    logic       kShift, keyDown, sdiBusy, siDelay;
    logic       addrAw;
    logic [7:0] Dout;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit m_fe, m_ko, m_so;          // sticky flags
    bit m_sh, m_kd, m_bz, m_si;    // live levels

    pokey_skstat_reg dut (
        .clk       (clk),
        .reset     (reset),
        .enn       (enn),
        .sdiOvrun  (sdiOvrun),
        .keyOvrun  (keyOvrun),
        .setFramer (setFramer),
        .kShift    (kShift),
        .keyDown   (keyDown),
        .sdiBusy   (sdiBusy),
        .siDelay   (siDelay),
        .addrAw    (addrAw),
        .Dout      (Dout)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Expected read value: start from all ones and subtract the weight of
    // each asserted (low-going) bit; siLvl is high-true.
    function automatic logic [7:0] model_dout();
        int v;
        v = 255;
        v -= 128 * int'(m_fe);
        v -= 64 * int'(m_ko);
        v -= 32 * int'(m_so);
        v -= 16 * (1 - int'(m_si));
        v -= 8 * int'(m_sh);
        v -= 4 * int'(m_kd);
        v -= 2 * int'(m_bz);
        return v[7:0];
    endfunction

    function automatic void model_reset();
        {m_fe, m_ko, m_so, m_sh, m_kd, m_bz} = '0;
        m_si = 1'b1;
    endfunction

    // What one enn tick does to the register, stated from the register rules.
    function automatic void model_tick();
        m_fe = setFramer ? 1'b1 : (addrAw ? 1'b0 : m_fe);
        m_ko = keyOvrun  ? 1'b1 : (addrAw ? 1'b0 : m_ko);
        m_so = sdiOvrun  ? 1'b1 : (addrAw ? 1'b0 : m_so);
        m_sh = kShift;
        m_kd = keyDown;
        m_bz = sdiBusy;
        m_si = siDelay;
    endfunction

    task automatic clear_inputs();
        {sdiOvrun, keyOvrun, setFramer, kShift, keyDown, sdiBusy, addrAw} = '0;
        siDelay = 1'b1;
    endtask

    // Inputs are held steady for several clocks before the strobe so the
    // optional synchronizers have settled; output sampled at the negedge one
    // clk after the sampling edge.
    task automatic tick();
        repeat (3) @(negedge clk);
        enn = 1'b1;
        @(negedge clk);
        enn = 1'b0;
        model_tick();
    endtask

    task automatic tick_check(input string tag);
        tick();
        check(tag, Dout, model_dout());
    endtask

    initial begin
        enn   = 1'b0;
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check("reset_dout", Dout, 8'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) tick();
        check("idle_10_ticks", Dout, 8'hFF);

        // Sticky flags accumulate and persist.
        sdiOvrun = 1'b1;  tick(); sdiOvrun = 1'b0;
        check("sdi_ovr_set", Dout, 8'hDF);
        keyOvrun = 1'b1;  tick(); keyOvrun = 1'b0;
        check("key_ovr_set", Dout, 8'h9F);
        setFramer = 1'b1; tick(); setFramer = 1'b0;
        check("frame_err_set", Dout, 8'h1F);
        tick();
        check("flags_persist", Dout, 8'h1F);

        // SKRES with enn held low must not act.
        addrAw = 1'b1;
        repeat (6) @(negedge clk);
        check("skres_no_enn", Dout, 8'h1F);
        // Event pulsed between ticks is missed.
        addrAw = 1'b0;
        tick();
        tick();
        check("flags_hold_again", Dout, 8'h1F);
        addrAw = 1'b1; tick(); addrAw = 1'b0;
        check("skres_clear", Dout, 8'hFF);

        sdiOvrun = 1'b1;
        repeat (2) @(negedge clk);
        sdiOvrun = 1'b0;
        tick();
        check("event_between_ticks_missed", Dout, 8'hFF);

        // Set beats clear on the same tick.
        sdiOvrun = 1'b1; addrAw = 1'b1; tick();
        sdiOvrun = 1'b0; addrAw = 1'b0;
        check("set_wins", Dout, 8'hDF);
        addrAw = 1'b1; tick(); addrAw = 1'b0;
        check("skres_after_set_wins", Dout, 8'hFF);

        // Live levels.
        kShift = 1'b1; keyDown = 1'b1; sdiBusy = 1'b1; siDelay = 1'b0;
        tick();
        check("live_all_asserted", Dout, 8'hE1);
        siDelay = 1'b1; tick();
        check("live_si_high", Dout, 8'hF1);
        kShift = 1'b0; keyDown = 1'b0; sdiBusy = 1'b0; tick();
        check("live_released", Dout, 8'hFF);

        // Asynchronous reset mid-run, between clock edges.
        sdiOvrun = 1'b1; keyOvrun = 1'b1; setFramer = 1'b1; tick();
        clear_inputs();
        check("pre_reset_flags", Dout, 8'h1F);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", Dout, 8'hFF);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized ticks, with random chatter while enn is low.
        for (int i = 0; i < 300; i++) begin
            sdiOvrun  = ($urandom_range(0, 4) == 0);
            keyOvrun  = ($urandom_range(0, 4) == 0);
            setFramer = ($urandom_range(0, 4) == 0);
            addrAw    = ($urandom_range(0, 3) == 0);
            kShift    = 1'($urandom);
            keyDown   = 1'($urandom);
            sdiBusy   = 1'($urandom);
            siDelay   = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                // enn stays low: no state may change
                repeat (4) @(negedge clk);
                check("rand_hold", Dout, model_dout());
            end else begin
                tick_check("rand_tick");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pokey_skstat_reg.md
Name: pokey_skstat_reg

Overview:
- POKEY serial/keyboard status register (SKSTAT, read address $D20F).
- Latches the sticky error flags: framing error, keyboard overrun, serial-input overrun.
- Registers the live keyboard/serial status bits and presents all of them as an active-low 8-bit read value.
- Runs in the fast system clock domain; advances only on the 1.79 MHz negative-edge enable strobe. Cleared by a CPU write to SKRES (addrAw).

Parameters:
- None.

Ports:
- clk        in   1  system clock (50 MHz); all state changes on rising edge
- reset      in   1  asynchronous, active-high reset
- enn        in   1  one-clk-wide enable strobe (1.79 MHz negative-edge tick); state updates only when high
- sdiOvrun   in   1  serial data input overrun event, active high
- keyOvrun   in   1  keyboard overrun event, active high
- setFramer  in   1  serial framing error event, active high
- kShift     in   1  shift key held, active high (level)
- keyDown    in   1  key currently pressed, active high (level)
- sdiBusy    in   1  serial input shift register busy, active high (level)
- siDelay    in   1  delayed serial data input pin level
- addrAw     in   1  SKRES write strobe; clears the sticky flags
- Dout       out  8  SKSTAT read value

Behaviour:
- Register map (0 = asserted for bits 7:1):
  - Dout[7] = ~frameErr
  - Dout[6] = ~keyOvr
  - Dout[5] = ~sdiOvr
  - Dout[4] = siLvl (not inverted)
  - Dout[3] = ~shiftLvl
  - Dout[2] = ~keyLvl
  - Dout[1] = ~busyLvl
  - Dout[0] = 1 constant
- Reset (asynchronous, any time): frameErr = keyOvr = sdiOvr = 0, shiftLvl = keyLvl = busyLvl = 0, siLvl = 1. Dout = 8'hFF. Reset mid-operation discards all pending state immediately.
- All state registers load only on a clk rising edge with enn = 1. With enn = 0 all state holds, regardless of input activity.
- Sticky flags, per flag, on an enn cycle:
  - Corresponding event input high -> flag set to 1.
  - Else if addrAw high -> flag cleared to 0.
  - Else flag holds.
- Simultaneous event and addrAw on the same enn cycle: set wins. Only flags without a concurrent event clear.
- Events and addrAw are level-sampled. Holding an input high across several enn ticks is equivalent to one tick. An input asserted and removed between enn ticks is missed; sources must hold for at least one enn period.
- Live bits (shiftLvl, keyLvl, busyLvl, siLvl) copy kShift, keyDown, sdiBusy and siDelay on every enn cycle.
- Latency: an input change is visible on Dout one clk after the sampling enn edge. Dout is a pure combinational decode of the registered state (no further delay).
- Dout[0] is always 1, including during reset.
- No CPU read side effects: reading never clears flags.

Optional Feature:
- Macro: SKSTAT_SYNC_IN_EN
- Defined:
  - kShift, keyDown, sdiBusy and siDelay each pass through a 2-flop clk-domain synchronizer (reset to 0, 0, 0, 1 respectively) before enn sampling.
  - Live-bit latency becomes 3 clk after the input change, plus the wait to the next enn.
  - Sticky event inputs and addrAw are not synchronized.
- Undefined: the live inputs are sampled directly; latency is as in Behaviour.

Test Plan:
- Reset asserted with all inputs 0 -> Dout = 8'hFF. Release reset with all inputs low and run 10 enn ticks -> Dout stays 8'hFF.
- Pulse sdiOvrun high for one enn period -> Dout = 8'hDF. Then pulse keyOvrun -> 8'h9F. Then pulse setFramer -> 8'h1F. Flags persist after the inputs drop.
- With Dout = 8'h1F, hold addrAw high for one enn period -> Dout = 8'hFF. addrAw high with enn held low -> no change.
- Drive sdiOvrun and addrAw high in the same enn cycle from Dout = 8'hFF -> Dout = 8'hDF (set wins). Then assert addrAw alone -> 8'hFF.
- Set kShift = keyDown = sdiBusy = 1, siDelay = 0 -> after the next enn, Dout = 8'hE1. Then siDelay = 1 -> 8'hF1. Drop kShift/keyDown/sdiBusy -> 8'hFF.
- With sticky flags set (Dout = 8'h1F), assert reset mid-run -> Dout = 8'hFF on the same cycle, without waiting for a clk edge.
